// File: rtl/char_pkg.sv
// Shared character/word types for the string-processing pipeline.
// Used by the serializer and the leading-character counter.
package char_pkg;

   localparam int NCHAR = 8;
   localparam int CW    = 8;
   localparam int LENW  = $clog2(NCHAR + 1);
   localparam int IDXW  = $clog2(NCHAR);

   localparam logic [CW-1:0] NUL = 8'h00;

   typedef logic [CW-1:0]    char_t;
   typedef char_t [NCHAR-1:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/lead_nonzero_count.sv
// Counts characters in front of the first NUL of a packed word.
// A word with no NUL reports the full width.
module lead_nonzero_count #(
   parameter int NCHAR = 8,
   parameter int CW    = 8,
   parameter int LENW  = $clog2(NCHAR + 1)
) (
   input  logic [NCHAR-1:0][CW-1:0] word_i,
   output logic [LENW-1:0]          len_o
);

   logic found;

   // Scan from index 0; the first NUL fixes the length.
   always_comb begin
      len_o = LENW'(NCHAR);
      found = 1'b0;
      for (int i = 0; i < NCHAR; i++) begin
         if (!found && (word_i[i] == '0)) begin
            len_o = LENW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/char_word_serializer.sv
// Streams the compacted characters of one word per cycle,
// flagging the last one; empty words are dropped with a pulse.
module char_word_serializer
   import char_pkg::*;
#(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  word_t           in_word,
   output logic            out_valid,
   input  logic            out_ready,
   output char_t           out_char,
   output logic            out_last,
   output logic            empty_word,
   output logic [CNTW-1:0] chars_sent
);

   state_e          state_q, state_d;
   word_t           buf_q, buf_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [LENW-1:0] len_q, len_d;
   logic [LENW-1:0] new_len;
   logic            empty_q, empty_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            xfer;
   logic            accept;
   logic            last;

   lead_nonzero_count #(
      .NCHAR (NCHAR),
      .CW    (CW),
      .LENW  (LENW)
   ) u_len (
      .word_i (in_word),
      .len_o  (new_len)
   );

   assign out_valid  = (state_q == SEND);
   assign last       = out_valid &&
                       (LENW'(idx_q) == (len_q - LENW'(1)));
   assign out_last   = last;
   assign out_char   = out_valid ? buf_q[idx_q] : NUL;
   assign xfer       = out_valid & out_ready;
   // Last-beat transfer frees the buffer in the same cycle.
   assign in_ready   = (state_q == IDLE) | (xfer & last);
   assign accept     = in_valid & in_ready;
   assign empty_word = empty_q;
   assign chars_sent = cnt_q;

   // Next-state: load on accept, advance or retire on transfer.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      len_d   = len_q;
      empty_d = 1'b0;
      cnt_d   = cnt_q;
      if (xfer) begin
         cnt_d = cnt_q + CNTW'(1);
      end
      if (accept) begin
         buf_d   = in_word;
         len_d   = new_len;
         idx_d   = '0;
         if (new_len == '0) begin
            state_d = IDLE;
            empty_d = 1'b1;
         end else begin
            state_d = SEND;
         end
      end else if (xfer) begin
         if (last) begin
            state_d = IDLE;
         end else begin
            idx_d = idx_q + IDXW'(1);
         end
      end
   end

   // State registers; reset discards any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         empty_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         empty_q <= empty_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_char_word_serializer.sv
// Directed and random stimulus against a queue-based model
// of the word serializer.
module tb_char_word_serializer;
   import char_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   word_t       in_word;
   logic        out_valid;
   logic        out_ready;
   char_t       out_char;
   logic        out_last;
   logic        empty_word;
   logic [15:0] chars_sent;

   int nerr;
   int nchk;

   logic [7:0]  cur[$];
   bit          emp_m;
   int unsigned cnt_m;

   char_word_serializer #(.CNTW(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_word    (in_word),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_char   (out_char),
      .out_last   (out_last),
      .empty_word (empty_word),
      .chars_sent (chars_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic word_t mk(input string s);
      word_t w;
      for (int i = 0; i < NCHAR; i++)
         w[i] = (i < s.len()) ? s[i] : 8'h00;
      return w;
   endfunction

   function automatic word_t rnd_word();
      word_t w;
      for (int i = 0; i < NCHAR; i++)
         w[i] = ($urandom % 4 == 0) ? 8'h00
                : 8'(97 + $urandom % 26);
      return w;
   endfunction

   // One clock: check outputs at negedge, advance model after edge.
   task automatic cycle(output bit acc);
      bit xfer;
      bit rdy;
      logic [7:0] exp_c;
      @(negedge clk);
      exp_c = (cur.size() != 0) ? cur[0] : 8'h00;
      rdy = (cur.size() == 0) ||
            (out_ready && cur.size() == 1);
      chk("out_valid", 32'(out_valid), 32'(cur.size() != 0));
      chk("out_char", 32'(out_char), 32'(exp_c));
      chk("out_last", 32'(out_last), 32'(cur.size() == 1));
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("empty_word", 32'(empty_word), 32'(emp_m));
      chk("chars_sent", 32'(chars_sent), cnt_m & 32'hffff);
      xfer = (cur.size() != 0) && out_ready;
      acc  = in_valid && rdy;
      @(posedge clk);
      #1;
      if (xfer) begin
         void'(cur.pop_front());
         cnt_m++;
      end
      emp_m = 1'b0;
      if (acc) begin
         cur.delete();
         for (int i = 0; i < NCHAR; i++) begin
            if (in_word[i] == 8'h00) break;
            cur.push_back(in_word[i]);
         end
         emp_m = (cur.size() == 0);
      end
   endtask

   task automatic drain(input int bound);
      bit a;
      int n;
      n = 0;
      while ((cur.size() != 0 || emp_m) && n < bound) begin
         cycle(a);
         n++;
      end
      chk("drain_left", 32'(cur.size()), 32'd0);
   endtask

   task automatic send(input word_t w);
      bit a;
      int n;
      in_word  = w;
      in_valid = 1'b1;
      n = 0;
      a = 1'b0;
      while (!a && n < 40) begin
         cycle(a);
         n++;
      end
      chk("accept_timeout", 32'(a), 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      bit    a;
      int    k;
      word_t w;
      bit    pat[4];
      nerr = 0;
      nchk = 0;
      cnt_m = 0;
      emp_m = 1'b0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_word = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_char", 32'(out_char), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_empty", 32'(empty_word), 32'd0);
      chk("rst_cnt", 32'(chars_sent), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(a);

      // b,c,d then NULs
      out_ready = 1'b1;
      send(mk("bcd"));
      drain(20);
      chk("cnt_bcd", 32'(chars_sent), 32'd3);

      // full word, second word queued behind it
      send(mk("bcdfghjk"));
      send(mk("lmn"));
      drain(20);

      // all-zero word, next word right after
      send('0);
      send(mk("zz"));
      drain(20);

      // bytes after the first NUL are ignored
      w = mk("x");
      w[2] = "y";
      w[5] = "q";
      send(w);
      drain(20);

      // back-pressure pattern 1,0,0,1
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b1;
      send(mk("pqr"));
      k = 0;
      while (cur.size() != 0 && k < 40) begin
         out_ready = pat[k % 4];
         cycle(a);
         k++;
      end
      chk("pqr_left", 32'(cur.size()), 32'd0);
      out_ready = 1'b1;
      cycle(a);

      // reset in the middle of a word at idx 2
      send(mk("bcdfg"));
      cycle(a);
      cycle(a);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_cnt", 32'(chars_sent), 32'd0);
      chk("mid_rst_char", 32'(out_char), 32'd0);
      chk("mid_rst_last", 32'(out_last), 32'd0);
      cur.delete();
      cnt_m = 0;
      emp_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(mk("tv"));
      drain(20);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 2) == 0;
         out_ready = ($urandom % 4) != 0;
         in_word   = rnd_word();
         cycle(a);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain(20);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/char_word_serializer.md
Name: char_word_serializer

Overview:
- Downstream consumer of the vowel-elimination stage.
- Accepts one packed 8-character word per handshake, in which compacted characters occupy the low indices and 8'h00 pads the high indices.
- Streams the valid characters out one per cycle, index 0 first, over a valid/ready interface, and flags the final character of each word.
- Feeds the text output / UART-TX path of the string-processing pipeline.

Parameters:
- NCHAR, 8, characters per input word.
- CW, 8, bits per character (ASCII).
- CNTW, 16, width of the sent-character statistics counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_word  input  NCHAR x CW (packed [NCHAR-1:0][CW-1:0])  compacted characters, element 0 = first character.
- out_valid  output  1  out_char holds a character.
- out_ready  input  1  downstream accepts the character.
- out_char  output  CW  current character; 0 when out_valid=0.
- out_last  output  1  out_char is the last character of the current word.
- empty_word  output  1  one-cycle pulse: an accepted word contained no characters.
- chars_sent  output  CNTW  count of characters transferred since reset, wraps.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; buffer=0; idx=0; len=0; out_valid=0; out_char=0; out_last=0; empty_word=0; chars_sent=0. in_ready=1 as soon as reset is released.
- States:
  - IDLE: no character held.
  - SEND: holding a word, emitting buf[idx].
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). The combinational path from out_ready is intentional and gives back-to-back throughput of len cycles per word.
- Accept (in_valid & in_ready):
  - Register in_word into the buffer.
  - len = number of leading non-zero characters, i.e. the index of the first 8'h00, or NCHAR if none.
  - Bytes after the first 8'h00 are ignored even if non-zero.
- Accept with len>0: next state SEND, idx=0.
- Accept with len==0: word dropped; empty_word=1 in the following cycle only; state becomes or stays IDLE. Example: a word that was all vowels upstream.
- SEND:
  - out_valid=1, out_char=buf[idx], out_last=(idx==len-1).
  - Transfer (out_valid & out_ready): chars_sent+=1, wrapping at 2^CNTW.
  - If not last: idx+=1.
  - If last: either load the new word (when in_valid is high in the same cycle) or go to IDLE.
- out_ready=0 while in SEND: out_char, out_last and idx hold stable; no character is skipped or duplicated.
- Latency: a word accepted at edge N presents its first character with out_valid=1 after edge N (cycle N+1).
- out_valid never depends combinationally on out_ready.
- idx never exceeds NCHAR-1; len ranges 0..NCHAR and is stored in $clog2(NCHAR+1) bits.
- Reset asserted mid-word: the word is discarded, and all outputs return to their reset values immediately (asynchronously).

Decomposition:
- Shared package char_pkg:
  - CW and NCHAR constants.
  - NUL=8'h00.
  - typedefs char_t (logic [CW-1:0]) and word_t (char_t [NCHAR-1:0]).
  - State enum {IDLE, SEND}.
- One combinational sub-module, lead_nonzero_count: word_t in, returns len (count of characters before the first NUL). Reusable by other string stages.
- FSM, buffer, idx and counter live in char_word_serializer.

Test Plan:
- Reset, then accept word "b","c","d",0,0,0,0,0 with out_ready=1 → three beats 'b','c','d', out_last only on 'd', chars_sent=3, in_ready high on the 'd' transfer cycle.
- Full word "bcdfghjk" (no NUL) with out_ready=1 → 8 consecutive beats, out_last on 'k'. A second word held on in_valid is accepted on the 'k' cycle and its first character appears the next cycle with no bubble.
- All-zero word → no out_valid; empty_word high for exactly one cycle; chars_sent unchanged; next word accepted the following cycle.
- Word "x",0,"y",... → single beat 'x' with out_last=1; 'y' is never emitted.
- out_ready toggled 1,0,0,1,… on word "pqr" → each character is held while out_ready=0; sequence p,q,r exactly once; in_ready stays 0 until the 'r' transfer.
- rst_n pulsed low while in SEND at idx=2 → out_valid=0, chars_sent=0 immediately; after release in_ready=1 and the next word streams from index 0.
